mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory between the pipeline's instruction-fetch stage and its data-access stage. Grants the port combinationally each cycle, since the memory reads combinationally and writes on the clock edge. Absorbs stores into a one-entry store buffer with read forwarding. Returns per-requester stall signals to the hazard unit.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/store_buffer.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned WAW = AW - 2;

  // Masks off the byte offset so only word addresses take part in a compare.
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_DLOAD = 2'd1,
    GNT_FETCH = 2'd2,
    GNT_DRAIN = 2'd3
  } grant_t;

  // One buffered full-word store.
  typedef struct packed {
    logic [WAW-1:0] addr;
    logic [DW-1:0]  data;
  } sb_entry_t;

  // True when two byte addresses fall in the same 32-bit word.
  function automatic logic word_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return ((a ^ b) & WORD_MASK) == '0;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// One-entry store buffer with two hit-compare ports for read forwarding.
module store_buffer
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [WAW-1:0]        load_addr_i,
  input  logic [DW-1:0]         load_data_i,
  input  logic                  drain_i,
  input  logic [AW-1:0]         cmp_a_addr_i,
  input  logic [AW-1:0]         cmp_b_addr_i,
  output logic                  valid_o,
  output sb_entry_t             entry_o,
  output logic                  hit_a_c_o,
  output logic                  hit_b_c_o
);

  logic      valid_q, valid_d;
  sb_entry_t entry_q, entry_d;

  // Next entry: a drain empties the buffer unless a store refills it on the same edge.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (drain_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d      = 1'b1;
      entry_d.addr = load_addr_i;
      entry_d.data = load_data_i;
    end
  end

  // Buffer state; reset discards any pending store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  // Word-address hit compares against the buffered store.
  always_comb begin
    hit_a_c_o = valid_q && word_match({entry_q.addr, 2'b00}, cmp_a_addr_i);
    hit_b_c_o = valid_q && word_match({entry_q.addr, 2'b00}, cmp_b_addr_i);
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// with a one-entry forwarding store buffer and fetch starvation protection.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CW           = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  logic          ld_c, st_c;
  logic          sb_valid;
  sb_entry_t     sb_entry;
  logic          sb_hit_if_c, sb_hit_d_c;
  logic          if_hit_c, d_hit_c;
  logic          if_miss_c, ld_miss_c;
  logic          store_blocked_c;
  grant_t        grant_c;
  logic [CW-1:0] starve_q, starve_d;

  // A stalled store is still written into the buffer: the forced drain frees it
  // this cycle and the re-presented store then hits as a same-word overwrite.
  store_buffer u_sb (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (st_c),
    .load_addr_i  (d_addr[AW-1:2]),
    .load_data_i  (d_wdata),
    .drain_i      (grant_c == GNT_DRAIN),
    .cmp_a_addr_i (if_addr),
    .cmp_b_addr_i (d_addr),
    .valid_o      (sb_valid),
    .entry_o      (sb_entry),
    .hit_a_c_o    (sb_hit_if_c),
    .hit_b_c_o    (sb_hit_d_c)
  );

  // Request decode and buffer hit/miss classification.
  always_comb begin
    ld_c            = d_req && !d_we;
    st_c            = d_req && d_we;
    if_hit_c        = if_req && sb_hit_if_c;
    d_hit_c         = ld_c && sb_hit_d_c;
    if_miss_c       = if_req && !sb_hit_if_c;
    ld_miss_c       = ld_c && !sb_hit_d_c;
    store_blocked_c = st_c && sb_valid && !sb_hit_d_c;
  end

  // Fixed-priority port grant, one winner per cycle.
  always_comb begin
    grant_c = GNT_NONE;
    if (store_blocked_c) begin
      grant_c = GNT_DRAIN;
    end else if (starve_q == CW'(STARVE_LIMIT) && if_miss_c) begin
      grant_c = GNT_FETCH;
    end else if (ld_miss_c) begin
      grant_c = GNT_DLOAD;
    end else if (if_miss_c) begin
      grant_c = GNT_FETCH;
    end else if (sb_valid) begin
      grant_c = GNT_DRAIN;
    end
  end

  // Memory port drive, read-data steering and stall generation.
  always_comb begin
    m_addr   = '0;
    m_we     = 1'b0;
    m_wdata  = '0;
    if_rdata = '0;
    d_rdata  = '0;
    unique case (grant_c)
      GNT_DLOAD: m_addr = d_addr;
      GNT_FETCH: m_addr = if_addr;
      GNT_DRAIN: begin
        m_addr  = {sb_entry.addr, 2'b00};
        m_wdata = sb_entry.data;
        m_we    = 1'b1;
      end
      default: m_addr = '0;
    endcase
    if (grant_c == GNT_FETCH) begin
      if_rdata = m_rdata;
    end else if (if_hit_c) begin
      if_rdata = sb_entry.data;
    end
    if (grant_c == GNT_DLOAD) begin
      d_rdata = m_rdata;
    end else if (d_hit_c) begin
      d_rdata = sb_entry.data;
    end
    if_stall = if_miss_c && (grant_c != GNT_FETCH);
    d_stall  = (ld_miss_c && (grant_c != GNT_DLOAD)) || store_blocked_c;
  end

  // Starvation count: consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_d = '0;
    if (if_stall) begin
      starve_d = (starve_q == CW'(STARVE_LIMIT)) ? starve_q : starve_q + CW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural memory.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        mem_rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  int          n_checks;
  int          n_errors;

  mem_port_arbiter #(.STARVE_LIMIT(3), .CW(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_stall (if_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_stall  (d_stall),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge; own init reset.
  always @(posedge clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | 32'(i * 4);
    end else if (m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
  end
  assign m_rdata = mem[m_addr[9:2]];

  function automatic logic [31:0] memv(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  // Fetch 0x100 and load 0x200 contend; from a cleared count fetch wins every 4th cycle.
  task automatic contend(input int n);
    logic fw;
    for (int k = 0; k < n; k++) begin
      next_cycle();
      set_in(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
      fw = ((k % 4) == 3);
      push(32'(!fw));
      push(32'(fw));
      push(fw ? 32'h100 : 32'h200);
      push(fw ? memv(32'h100) : 32'h0);
      push(fw ? 32'h0 : memv(32'h200));
      @(negedge clk);
      chk("contend_if_stall", 32'(if_stall));
      chk("contend_d_stall", 32'(d_stall));
      chk("contend_m_addr", m_addr);
      chk("contend_if_rdata", if_rdata);
      chk("contend_d_rdata", d_rdata);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    mem_rst_n = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    push(32'h0); push(32'h0); push(32'h0); push(32'h0);
    chk("rst_m_we", 32'(m_we));
    chk("rst_m_addr", m_addr);
    chk("rst_if_stall", 32'(if_stall));
    chk("rst_d_stall", 32'(d_stall));

    next_cycle();
    reset_n   = 1'b1;
    mem_rst_n = 1'b1;

    // Lone fetch
    set_in(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h100); push(32'h0); push(32'h0); push(memv(32'h100));
    @(negedge clk);
    chk("fetch_m_addr", m_addr);
    chk("fetch_m_we", 32'(m_we));
    chk("fetch_if_stall", 32'(if_stall));
    chk("fetch_if_rdata", if_rdata);

    // Starvation protection
    contend(8);

    // Idle
    next_cycle();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("idle_m_we", 32'(m_we));
    chk("idle_m_addr", m_addr);

    // Store A to 0x40 is absorbed
    next_cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("stA_d_stall", 32'(d_stall));
    chk("stA_m_we", 32'(m_we));

    // Load 0x40 forwarded from buffer while fetch uses the port
    next_cycle();
    set_in(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0);
    push(32'hDEAD_BEEF); push(32'h0); push(32'h0); push(32'h100); push(32'h0);
    push(memv(32'h100)); push(memv(32'h40));
    @(negedge clk);
    chk("fwd_d_rdata", d_rdata);
    chk("fwd_d_stall", 32'(d_stall));
    chk("fwd_if_stall", 32'(if_stall));
    chk("fwd_m_addr", m_addr);
    chk("fwd_m_we", 32'(m_we));
    chk("fwd_if_rdata", if_rdata);
    chk("fwd_mem40_unwritten", mem[8'h10]);

    // Store B to 0x80 is blocked; forced drain of A
    next_cycle();
    set_in(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'hB0B0_B0B0);
    push(32'h1); push(32'h1); push(32'h40); push(32'hDEAD_BEEF); push(32'h1);
    @(negedge clk);
    chk("blk_d_stall", 32'(d_stall));
    chk("blk_m_we", 32'(m_we));
    chk("blk_m_addr", m_addr);
    chk("blk_m_wdata", m_wdata);
    chk("blk_if_stall", 32'(if_stall));

    // Store B retried: accepted, fetch served
    next_cycle();
    push(32'h0); push(32'h0); push(32'h0); push(32'h100); push(32'hDEAD_BEEF);
    @(negedge clk);
    chk("retry_d_stall", 32'(d_stall));
    chk("retry_if_stall", 32'(if_stall));
    chk("retry_m_we", 32'(m_we));
    chk("retry_m_addr", m_addr);
    chk("retry_mem40", mem[8'h10]);

    // Idle cycle drains B
    next_cycle();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h1); push(32'h80); push(32'hB0B0_B0B0);
    @(negedge clk);
    chk("drain_m_we", 32'(m_we));
    chk("drain_m_addr", m_addr);
    chk("drain_m_wdata", m_wdata);

    // Buffer now empty
    next_cycle();
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("empty_m_we", 32'(m_we));
    chk("empty_m_addr", m_addr);

    // Load 0x80 from memory
    next_cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    push(32'h80); push(32'hB0B0_B0B0); push(32'h0);
    @(negedge clk);
    chk("ld80_m_addr", m_addr);
    chk("ld80_d_rdata", d_rdata);
    chk("ld80_d_stall", 32'(d_stall));

    // Store C to 0x80 into empty buffer
    next_cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hC0C0_C0C0);
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("stC_d_stall", 32'(d_stall));
    chk("stC_m_we", 32'(m_we));

    // Store D overwrites same word while C drains
    next_cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hD0D0_D0D0);
    push(32'h0); push(32'h1); push(32'h80); push(32'hC0C0_C0C0);
    @(negedge clk);
    chk("stD_d_stall", 32'(d_stall));
    chk("stD_m_we", 32'(m_we));
    chk("stD_m_addr", m_addr);
    chk("stD_m_wdata", m_wdata);

    // Buffer kept D: load hit forwards it while D drains
    next_cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    push(32'hD0D0_D0D0); push(32'h0); push(32'h1); push(32'hD0D0_D0D0);
    @(negedge clk);
    chk("hitD_d_rdata", d_rdata);
    chk("hitD_d_stall", 32'(d_stall));
    chk("hitD_m_we", 32'(m_we));
    chk("hitD_m_wdata", m_wdata);

    // Load 0x80 from memory sees D
    next_cycle();
    push(32'hD0D0_D0D0); push(32'h0);
    @(negedge clk);
    chk("memD_d_rdata", d_rdata);
    chk("memD_m_we", 32'(m_we));

    // Store E to 0xC0, then contend to raise the starvation count
    next_cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'hC0, 32'hEEEE_EEEE);
    push(32'h0);
    @(negedge clk);
    chk("stE_d_stall", 32'(d_stall));
    contend(2);

    // Mid-cycle reset with E pending and count at 2
    next_cycle();
    set_in(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
    #1;
    reset_n = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    push(32'h0); push(32'h0); push(32'h0); push(32'h0);
    chk("mrst_m_we", 32'(m_we));
    chk("mrst_m_addr", m_addr);
    chk("mrst_if_stall", 32'(if_stall));
    chk("mrst_d_stall", 32'(d_stall));
    @(negedge clk);
    next_cycle();
    reset_n = 1'b1;

    // Count restarted from zero
    contend(4);

    // Pending store was discarded: 0xC0 still holds its original word
    next_cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'hC0, 32'h0);
    push(memv(32'hC0)); push(32'hC0); push(32'h0);
    @(negedge clk);
    chk("post_rst_d_rdata", d_rdata);
    chk("post_rst_m_addr", m_addr);
    chk("post_rst_m_we", 32'(m_we));

    next_cycle();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h0); push(memv(32'hC0));
    @(negedge clk);
    chk("post_rst_idle_m_we", 32'(m_we));
    chk("post_rst_memC0", mem[8'h30]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
